// File: rtl/mac_accum_seq.sv
// mac_accum_seq
// Accumulation sequencer for one neuron. Takes N_INPUTS signed products per
// group, accumulates them with per-addition saturation, adds the neuron bias
// and offers the saturated result downstream over a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active high
//   in_valid    product valid
//   in_ready    sequencer accepts a product this cycle (IDLE or ACCUM)
//   in_product  signed product from the multiplier
//   bias        signed neuron bias, held stable from group start to output handshake
//   acc_sel     accumulator mux select: 0 = load product, 1 = accumulate
//   out_valid   out_sum is valid
//   out_ready   downstream accepts out_sum
//   out_sum     saturated sum(products) + bias
//   sat_flag    sticky saturation indication for the current group
//   busy        sequencer is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for the first product of a group (load, not accumulate)
// ACCUM | accumulating products 2..N_INPUTS
// BIAS  | single cycle adding the bias to the accumulator
// OUT   | result held on out_sum until the downstream handshake

module mac_accum_seq #(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_product,
  input  logic [WIDTH-1:0] bias,
  output logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             sat_flag,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_BIAS  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_s;
  logic             add_ovf;
  logic [WIDTH-1:0] add_res;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign acc_sel   = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign sat_flag  = sat_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  // One shared saturating adder: the bias replaces the product only in BIAS.
  // Overflow shows as disagreement between the two top bits of the
  // sign-extended sum; the extra top bit then gives the clamp direction.
  assign addend  = (state_q == S_BIAS) ? bias : in_product;
  assign add_s   = {acc_q[WIDTH-1], acc_q} + {addend[WIDTH-1], addend};
  assign add_ovf = add_s[WIDTH] ^ add_s[WIDTH-1];
  assign add_res = add_ovf ? (add_s[WIDTH] ? MIN_NEG : MAX_POS) : add_s[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          acc_d   = in_product;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
          state_d = (N_INPUTS == 1) ? S_BIAS : S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (in_xfer) begin
          acc_d = add_res;
          sat_d = sat_q | add_ovf;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            state_d = S_BIAS;
          end
        end
      end

      S_BIAS: begin
        // out_sum has its own register so it only changes when a new result
        // is published, not while the next group accumulates.
        acc_d       = add_res;
        out_sum_d   = add_res;
        sat_d       = sat_q | add_ovf;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mac_accum_seq.sv
module tb_mac_accum_seq;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct {
    logic [31:0] sum;
    logic        sat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, acc_sel, out_valid, out_ready, sat_flag, busy;
  logic [31:0] in_product, bias, out_sum;
  logic        in_valid1, in_ready1, acc_sel1, out_valid1, out_ready1, sat_flag1, busy1;
  logic [31:0] in_product1, bias1, out_sum1;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  mac_accum_seq #(.WIDTH(32), .N_INPUTS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .bias(bias),
    .acc_sel(acc_sel), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .sat_flag(sat_flag), .busy(busy)
  );

  mac_accum_seq #(.WIDTH(32), .N_INPUTS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_product(in_product1), .bias(bias1),
    .acc_sel(acc_sel1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .sat_flag(sat_flag1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint a);
    if (a > MAXV) return MAXV;
    if (a < MINV) return MINV;
    return a;
  endfunction

  function automatic exp_t model(input logic [31:0] prods[$], input logic [31:0] b);
    exp_t   e;
    longint acc;
    longint t;
    e.sat = 1'b0;
    acc = longint'($signed(prods[0]));
    for (int i = 1; i < prods.size(); i++) begin
      t = acc + longint'($signed(prods[i]));
      if (clamp(t) != t) e.sat = 1'b1;
      acc = clamp(t);
    end
    t = acc + longint'($signed(b));
    if (clamp(t) != t) e.sat = 1'b1;
    acc = clamp(t);
    e.sum = 32'(acc);
    return e;
  endfunction

  // Scoreboards: compare on the edge where an output handshake happens.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q0.size() == 0) chk("n4_unexpected_out", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("n4_out_sum", 64'(out_sum), 64'(e.sum));
        chk("n4_sat_flag", 64'(sat_flag), 64'(e.sat));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("n1_unexpected_out", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("n1_out_sum", 64'(out_sum1), 64'(e.sum));
        chk("n1_sat_flag", 64'(sat_flag1), 64'(e.sat));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the last accept.
  task automatic send_group(input logic [31:0] prods[$], input logic [31:0] b,
                            input bit gaps, input bit wait_done);
    q0.push_back(model(prods, b));
    bias = b;
    for (int i = 0; i < prods.size(); i++) begin
      int t = 0;
      in_product = prods[i];
      in_valid   = 1'b1;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("in_ready_timeout", 64'd1, 64'd0);
      chk("acc_sel_on_accept", 64'(acc_sel), (i == 0) ? 64'd0 : 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (gaps) @(negedge clk);
    end
    if (wait_done) wait_idle();
  endtask

  logic [31:0] pq[$];

  initial begin
    rst = 1'b1;
    in_valid = 0; in_product = 0; bias = 0; out_ready = 1'b1;
    in_valid1 = 0; in_product1 = 0; bias1 = 0; out_ready1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_acc_sel", 64'(acc_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic group and output latency
    pq = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_group(pq, 32'd10, 1'b0, 1'b0);
    chk("lat_after_accept_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_two_edges_valid", 64'(out_valid), 64'd1);
    chk("t1_out_sum_const", 64'(out_sum), 64'd20);
    wait_idle();

    // positive saturation, then a clean group clears sat_flag
    pq = '{32'h7FFFFFF0, 32'h00000100, 32'd0, 32'd0};
    send_group(pq, 32'd0, 1'b0, 1'b1);
    pq = '{32'd1, 32'd1, 32'd1, 32'd1};
    send_group(pq, 32'd0, 1'b1, 1'b1);

    // negative saturation mid-group then recovery (per-add clamping)
    pq = '{32'h80000010, 32'hFFFFFF00, 32'd5, 32'd0};
    send_group(pq, 32'hFFFFFFFD, 1'b0, 1'b1);

    // negative arithmetic
    pq = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB};
    send_group(pq, 32'hFFFFFFFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_out_sum_const", 64'(out_sum), 64'h00000000FFFFFFEB);
    wait_idle();

    // backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    pq = '{32'd100, 32'd200, 32'd300, 32'd400};
    send_group(pq, 32'd5, 1'b0, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk("bp_valid_timeout", 64'd1, 64'd0);
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_sum", 64'(out_sum), 64'd1005);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid   = (k % 2 == 0);
      in_product = 32'd999;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_idle", 64'(busy), 64'd0);
    pq = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_group(pq, 32'd0, 1'b0, 1'b1);

    // N_INPUTS=1 instance: IDLE -> BIAS -> OUT
    q1.push_back(model('{32'd7}, 32'd3));
    bias1 = 32'd3;
    in_product1 = 32'd7;
    in_valid1 = 1'b1;
    chk("n1_in_ready", 64'(in_ready1), 64'd1);
    chk("n1_acc_sel", 64'(acc_sel1), 64'd0);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("n1_bias_busy", 64'(busy1), 64'd1);
    chk("n1_bias_valid", 64'(out_valid1), 64'd0);
    chk("n1_bias_in_ready", 64'(in_ready1), 64'd0);
    @(negedge clk);
    chk("n1_out_valid", 64'(out_valid1), 64'd1);
    chk("n1_out_sum_const", 64'(out_sum1), 64'd10);
    @(negedge clk);
    chk("n1_back_idle", 64'(busy1), 64'd0);

    // async reset mid-group discards the partial sum
    in_product = 32'h7FFFFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_product = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_sat", 64'(sat_flag), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_acc_sel", 64'(acc_sel), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_sum", 64'(out_sum), 64'd0);
    chk("async_rst_sat", 64'(sat_flag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pq = '{32'd1, 32'd1, 32'd1, 32'd1};
    send_group(pq, 32'd0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
